uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with majority-vote bit decisions
// feeding a show-ahead FIFO that stores parity/framing flags with each word.
module uart_rx_fifo #(
    parameter int WIDTH     = 8,
    parameter int FCLK      = 50000000,
    parameter int FBAUD     = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                     clk50m,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic                     rx_ready,
    input  logic                     clr_ovr,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_perr,
    output logic                     rx_ferr,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     rx_overrun,
    output logic                     rx_idle
);
    localparam int BITP = FCLK / FBAUD;
    localparam int H    = BITP / 2;
    localparam int CW   = $clog2(BITP + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam logic [CW-1:0] C_LO  = CW'(H - 1);
    localparam logic [CW-1:0] C_MID = CW'(H);
    localparam logic [CW-1:0] C_HI  = CW'(H + 1);
    localparam logic [CW-1:0] C_END = CW'(BITP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               perr_q, perr_d, ferr_q, ferr_d;
    logic [1:0]         smp_q, smp_d;
    logic [AW-1:0]      wr_q, rd_q;
    logic [LW-1:0]      level_q;
    logic               ovr_q;
    logic [WIDTH+1:0]   mem [DEPTH];
    logic               rxs, maj, dec, push, pop, full, wr_en, frame_ferr;

    assign rxs        = s2_q;
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign dec        = cnt_q == C_HI;
    assign frame_ferr = ferr_q | ~maj;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            smp_q   <= 2'b11;
        end else begin
            s1_q    <= rx;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            smp_q   <= smp_d;
        end
    end

    // cnt free-runs outside IDLE; every transition into IDLE re-zeroes it
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == C_END) ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        smp_d   = {(cnt_q == C_MID) ? rxs : smp_q[1], (cnt_q == C_LO) ? rxs : smp_q[0]};
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: if (dec) begin
                state_d = maj ? IDLE : DATA;
                cnt_d   = maj ? '0 : cnt_d;
                idx_d   = '0;
            end
            DATA: if (dec) begin
                shift_d = {maj, shift_q[WIDTH-1:1]};
                idx_d   = (idx_q == 4'(WIDTH - 1)) ? '0 : idx_q + 4'd1;
                state_d = (idx_q != 4'(WIDTH - 1)) ? DATA : (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (dec) begin
                perr_d  = (PARITY == 1) ? (^shift_q ^ maj) : ~(^shift_q ^ maj);
                state_d = STOP;
                idx_d   = '0;
            end
            STOP: if (dec) begin
                ferr_d = frame_ferr;
                idx_d  = idx_q + 4'd1;
                if (idx_q == 4'(STOP_BITS - 1)) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign full     = level_q == LW'(DEPTH);
    assign rx_valid = level_q != '0;
    assign pop      = rx_valid & rx_ready;
    assign wr_en    = push & (~full | pop);

    always_ff @(posedge clk50m) begin
        if (wr_en) mem[wr_q] <= {frame_ferr, perr_q, shift_q};
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            wr_q    <= wr_en ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop ? rd_q + AW'(1) : rd_q;
            level_q <= level_q + LW'(wr_en) - LW'(pop);
            ovr_q   <= (push & full & ~pop) | (ovr_q & ~clr_ovr);
        end
    end

    assign rx_data    = rx_valid ? mem[rd_q][WIDTH-1:0] : '0;
    assign rx_perr    = rx_valid & mem[rd_q][WIDTH];
    assign rx_ferr    = rx_valid & mem[rd_q][WIDTH+1];
    assign rx_level   = level_q;
    assign rx_overrun = ovr_q;
    assign rx_idle    = state_q == IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into an 8N1 receiver and an 8E1 receiver,
// checking stored words, flags, FIFO level/overrun and reset behaviour.
module tb_uart_rx_fifo;
    localparam int BITP = 434;

    logic       clk50m = 1'b0, rst_n = 1'b0, rx = 1'b1, rxp = 1'b1;
    logic       rdy = 1'b0, rdyp = 1'b0, clr = 1'b0, clrp = 1'b0;
    logic [7:0] d_data, p_data;
    logic       d_perr, d_ferr, d_valid, d_ovr, d_idle;
    logic       p_perr, p_ferr, p_valid, p_ovr, p_idle;
    logic [2:0] d_level, p_level;
    int         checks = 0, fails = 0;

    always #10 clk50m = ~clk50m;

    uart_rx_fifo dut (
        .clk50m(clk50m), .rst_n(rst_n), .rx(rx), .rx_ready(rdy), .clr_ovr(clr),
        .rx_data(d_data), .rx_perr(d_perr), .rx_ferr(d_ferr), .rx_valid(d_valid),
        .rx_level(d_level), .rx_overrun(d_ovr), .rx_idle(d_idle)
    );

    uart_rx_fifo #(.PARITY(1)) dutp (
        .clk50m(clk50m), .rst_n(rst_n), .rx(rxp), .rx_ready(rdyp), .clr_ovr(clrp),
        .rx_data(p_data), .rx_perr(p_perr), .rx_ferr(p_ferr), .rx_valid(p_valid),
        .rx_level(p_level), .rx_overrun(p_ovr), .rx_idle(p_idle)
    );

    // frame bits are LSB first, bit 0 is the start bit
    task automatic send(input logic [11:0] f, input int n, input bit sel, input int gap);
        for (int c = 0; c < n * BITP; c++) begin
            if (sel) rxp = f[c / BITP];
            else rx = f[c / BITP];
            @(negedge clk50m);
        end
        rx = 1'b1;
        rxp = 1'b1;
        repeat (gap) @(negedge clk50m);
    endtask

    task automatic pop(input bit sel);
        if (sel) rdyp = 1'b1;
        else rdy = 1'b1;
        @(negedge clk50m);
        rdy = 1'b0;
        rdyp = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk50m);
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", d_valid); end
        checks++; if (d_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", d_level); end
        checks++; if (d_idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b want 1", d_idle); end
        checks++; if ({d_data, d_perr, d_ferr, d_ovr} !== 11'd0) begin fails++; $display("FAIL reset_outs: got %h want 0", {d_data, d_perr, d_ferr, d_ovr}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk50m);
    endtask

    task automatic test_basic;
        logic [9:0] f;
        f = {1'b1, 8'hA5, 1'b0};
        // start seen 3 edges in; stop decision at cnt=H+1 of bit 9 -> push lands on edge 4128
        for (int c = 0; c < 10 * BITP; c++) begin
            rx = f[c / BITP];
            @(negedge clk50m);
            if (c + 1 == 4127) begin
                checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early: got %b want 0", d_valid); end
            end
            if (c + 1 == 4128) begin
                checks++; if (d_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_rise: got %b want 1", d_valid); end
            end
        end
        rx = 1'b1;
        repeat (BITP) @(negedge clk50m);
        checks++; if (d_data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", d_data); end
        checks++; if ({d_perr, d_ferr} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {d_perr, d_ferr}); end
        checks++; if (d_level !== 3'd1) begin fails++; $display("FAIL basic_level: got %0d want 1", d_level); end
        pop(1'b0);
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL basic_pop: got %b want 0", d_valid); end
    endtask

    task automatic test_parity;
        send({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1, BITP);
        checks++; if (p_data !== 8'h07) begin fails++; $display("FAIL par_bad_data: got %h want 07", p_data); end
        checks++; if (p_perr !== 1'b1) begin fails++; $display("FAIL par_bad_perr: got %b want 1", p_perr); end
        pop(1'b1);
        send({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1, BITP);
        checks++; if (p_data !== 8'h07) begin fails++; $display("FAIL par_ok_data: got %h want 07", p_data); end
        checks++; if (p_perr !== 1'b0) begin fails++; $display("FAIL par_ok_perr: got %b want 0", p_perr); end
        checks++; if (p_level !== 3'd1) begin fails++; $display("FAIL par_level: got %0d want 1", p_level); end
        pop(1'b1);
    endtask

    task automatic test_framing;
        send({1'b0, 8'h3C, 1'b0}, 10, 1'b0, 2 * BITP);
        checks++; if (d_data !== 8'h3C) begin fails++; $display("FAIL ferr_data: got %h want 3c", d_data); end
        checks++; if ({d_ferr, d_perr} !== 2'b10) begin fails++; $display("FAIL ferr_flags: got %b want 10", {d_ferr, d_perr}); end
        send({1'b1, 8'h96, 1'b0}, 10, 1'b0, BITP);
        checks++; if (d_level !== 3'd2) begin fails++; $display("FAIL ferr_level: got %0d want 2", d_level); end
        pop(1'b0);
        checks++; if (d_data !== 8'h96) begin fails++; $display("FAIL ferr_next_data: got %h want 96", d_data); end
        checks++; if (d_ferr !== 1'b0) begin fails++; $display("FAIL ferr_next_flag: got %b want 0", d_ferr); end
        pop(1'b0);
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        repeat (20) @(negedge clk50m);
        checks++; if (d_idle !== 1'b0) begin fails++; $display("FAIL glitch_start: got idle %b want 0", d_idle); end
        repeat (80) @(negedge clk50m);
        rx = 1'b1;
        pop(1'b0);
        repeat (400) @(negedge clk50m);
        checks++; if (d_idle !== 1'b1) begin fails++; $display("FAIL glitch_idle: got %b want 1", d_idle); end
        checks++; if (d_level !== 3'd0) begin fails++; $display("FAIL glitch_level: got %0d want 0", d_level); end
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) send({1'b1, 8'(i), 1'b0}, 10, 1'b0, BITP);
        checks++; if (d_level !== 3'd4) begin fails++; $display("FAIL ovr_level: got %0d want 4", d_level); end
        checks++; if (d_ovr !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", d_ovr); end
        for (int i = 1; i <= 3; i++) begin
            checks++; if (d_data !== 8'(i)) begin fails++; $display("FAIL ovr_pop%0d: got %h want %h", i, d_data, 8'(i)); end
            pop(1'b0);
        end
        checks++; if (d_ovr !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", d_ovr); end
        clr = 1'b1;
        @(negedge clk50m);
        clr = 1'b0;
        checks++; if (d_ovr !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", d_ovr); end
        checks++; if (d_data !== 8'h04) begin fails++; $display("FAIL ovr_pop4: got %h want 04", d_data); end
    endtask

    task automatic test_reset_midframe;
        logic [9:0] f;
        f = {1'b1, 8'h55, 1'b0};
        checks++; if (d_level !== 3'd1) begin fails++; $display("FAIL mid_pre_level: got %0d want 1", d_level); end
        for (int c = 0; c < 4 * BITP + 200; c++) begin
            rx = f[c / BITP];
            @(negedge clk50m);
        end
        checks++; if (d_idle !== 1'b0) begin fails++; $display("FAIL mid_busy: got idle %b want 0", d_idle); end
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        checks++; if ({d_valid, d_level, d_ovr} !== 5'd0) begin fails++; $display("FAIL mid_rst_fifo: got %b want 0", {d_valid, d_level, d_ovr}); end
        checks++; if ({d_data, d_perr, d_ferr} !== 10'd0) begin fails++; $display("FAIL mid_rst_data: got %h want 0", {d_data, d_perr, d_ferr}); end
        checks++; if (d_idle !== 1'b1) begin fails++; $display("FAIL mid_rst_idle: got %b want 1", d_idle); end
        repeat (5) @(negedge clk50m);
        rst_n = 1'b1;
        repeat (BITP) @(negedge clk50m);
        checks++; if (d_level !== 3'd0) begin fails++; $display("FAIL mid_after_level: got %0d want 0", d_level); end
        send({1'b1, 8'h81, 1'b0}, 10, 1'b0, BITP);
        checks++; if (d_level !== 3'd1) begin fails++; $display("FAIL mid_new_level: got %0d want 1", d_level); end
        checks++; if ({d_ferr, d_perr, d_data} !== 10'h081) begin fails++; $display("FAIL mid_new_word: got %h want 081", {d_ferr, d_perr, d_data}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_framing;
        test_glitch;
        test_overrun;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
